// File: rtl/reg_file_16.sv
// reg_file_16: two-read / one-write register file for the 16-bit MIPS datapath.
//
// Read port A feeds the ALU A input; read port B feeds the ALU-source mux.
// Writes arrive from writeback, at most one per clock. Register 0 is
// hardwired to zero: writes to it are dropped and reads of it return 0.
//
// Optional feature (macro REGFILE_BYPASS_EN):
//   defined   - write-through: a read of the register being written this
//               cycle returns wr_data combinationally, per port.
//   undefined - a read returns the stored value until the capturing edge.
//
// Reset is asynchronous and active-high. It clears every register at once.
// While rst is high, both read ports return 0. A write presented during
// reset is lost.

module reg_file_16 #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr_a,
  output logic [DATA_W-1:0] rd_data_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic [DATA_W-1:0] rd_data_b
);

  localparam int NREG = 1 << ADDR_W;

  logic [DATA_W-1:0] regs [0:NREG-1];

  // A write commits only when enabled and aimed at a nonzero register.
  logic wr_fire;
  assign wr_fire = wr_en && (wr_addr != '0);

  // Storage: async clear of every register, then one write per rising edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        regs[i] <= '0;
      end
    end else if (wr_fire) begin
      regs[wr_addr] <= wr_data;
    end
  end

  // Read port A: address 0 forced to zero; optional same-cycle write-through.
  always_comb begin
    rd_data_a = '0;
    if (rd_addr_a != '0) begin
      rd_data_a = regs[rd_addr_a];
`ifdef REGFILE_BYPASS_EN
      // Bypass is suppressed during reset so the ports still read 0.
      if (!rst && wr_fire && (wr_addr == rd_addr_a)) begin
        rd_data_a = wr_data;
      end
`endif
    end
  end

  // Read port B: same decode as port A, fully independent of it.
  always_comb begin
    rd_data_b = '0;
    if (rd_addr_b != '0) begin
      rd_data_b = regs[rd_addr_b];
`ifdef REGFILE_BYPASS_EN
      if (!rst && wr_fire && (wr_addr == rd_addr_b)) begin
        rd_data_b = wr_data;
      end
`endif
    end
  end

endmodule

// File: doc/reg_file_16.md
# reg_file_16

Two-read / one-write register file supplying the 16-bit operands of the MIPS datapath. It sits directly upstream of the 16-bit 2:1 operand muxes: read port A feeds the ALU A input, and read port B feeds the ALU-source mux beside the sign-extended immediate. Writes come from the writeback stage once per clock. Register 0 is hardwired to zero.

## Interface
- `DATA_W`, 16, register and port data width
- `ADDR_W`, 4, register address width; register count is 2^ADDR_W (16)
- `clk` input 1 — single clock; all state updates on the rising edge
- `rst` input 1 — asynchronous, active-high reset; clears every register
- `wr_en` input 1 — write strobe, sampled on the rising edge of `clk`
- `wr_addr` input ADDR_W — destination register
- `wr_data` input DATA_W — value to write
- `rd_addr_a` input ADDR_W — read port A address
- `rd_data_a` output DATA_W — read port A data (combinational)
- `rd_addr_b` input ADDR_W — read port B address
- `rd_data_b` output DATA_W — read port B data (combinational)

## Operation
- Storage: 2^ADDR_W registers of DATA_W bits.
- Write: on the rising `clk` edge with `rst` low, if `wr_en`=1 and `wr_addr`≠0, then `regs[wr_addr]` ← `wr_data`. If `wr_en`=0, nothing changes.
- Register 0: writes to address 0 are discarded, and any read of address 0 returns 0. This holds in every configuration, including bypass.
- Read: each port is a combinational decode of its address. There is no read enable. Reads never alter state.
- Port independence: A and B may address the same register, and both then return the same value.
- Reset: while `rst`=1, every register is 0, so `rd_data_a` and `rd_data_b` read 0 for all addresses. A write presented while `rst` is asserted is lost. Reset asserted mid-operation clears all registers immediately, without waiting for a clock edge.
- Same-cycle read and write to the same nonzero address: the result is set by `REGFILE_BYPASS_EN` (see Configuration).
- Address width: addresses are never out of range, because all 2^ADDR_W codes are valid registers.

## Timing
- Write latency: 1 clock. Data is visible on a read port after the edge that captures it, or in the same cycle when bypass is enabled.
- Read latency: 0 clocks, combinational from address (and from write inputs when bypass is enabled) to data.
- Reset assertion takes effect asynchronously.
- Reset deassertion is synchronous to operation: the first write can land on the first rising edge after `rst` falls.
- Output values at reset: `rd_data_a` = 0 and `rd_data_b` = 0.
- Sustained throughput: one write per cycle and two reads per cycle, with no stalls.

## Configuration
- Macro: `REGFILE_BYPASS_EN`.
- Defined (write-through):
  - If `wr_en`=1, `wr_addr`≠0 and `rd_addr_x`==`wr_addr`, then `rd_data_x` = `wr_data` in the same cycle.
  - This applies to each port independently.
  - It removes the writeback-to-decode hazard in the pipeline.
- Not defined:
  - `rd_data_x` returns the stored, pre-write value until the capturing edge.
  - The new value appears in the following cycle.

## Test plan
- **Reset clear:** write 0xBEEF to r5, then pulse `rst` between clock edges.
  - `rd_data_a` (addr 5) reads 0x0000 immediately, before the next edge.
- **Basic write/read:** write r3←0x1234 and r9←0xA5A5 on consecutive cycles, then read A=3 and B=9.
  - A=0x1234, B=0xA5A5.
  - Reading A=B=9 gives 0xA5A5 on both ports.
- **Register 0:** write r0←0xFFFF with `wr_en`=1.
  - A=0 reads 0x0000 on that cycle and every later cycle, in both configurations.
- **Write disabled:** r7 holds 0x0042; present `wr_addr`=7, `wr_data`=0x9999 with `wr_en`=0 for 3 edges.
  - r7 still reads 0x0042.
- **Same-cycle read/write:** r4 holds 0x1111; in one cycle write r4←0x2222 while A=4 and B=4.
  - With bypass defined: both ports show 0x2222 in that cycle.
  - Without bypass: both show 0x1111, then 0x2222 after the edge.
- **Back-to-back sweep:** write rN←N×0x0101 for N=1..15 on 15 consecutive cycles, then read all pairs.
  - Every read matches, and r0 reads 0.
